// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
//   Shares the single LC-3 memory/IO port between the CPU datapath (MAR/MDR, MIO_EN, R_W, R)
//   and one secondary requester (DMA/video/console). Round-robin grant on conflict. The
//   winner's command is latched and driven on the memory port until mem_ready, then the
//   owner alone sees a one-cycle ready pulse. All outputs are registered.
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  (in)        CPU command, req held until cpu_ready
//   cpu_rdata, cpu_ready   (out)       CPU read data (registered), completion pulse
//   dev_req/we/addr/wdata  (in)        device command, same rules as CPU
//   dev_rdata, dev_ready   (out)       device read data (registered), completion pulse
//   mem_en/we/addr/wdata   (out)       memory port command
//   mem_rdata, mem_ready   (in)        memory read data / completion (sampled only in XFER)
//   grant                  (out)       one-hot owner {dev,cpu}, 2'b00 when idle
//   err                    (out)       sticky timeout flag
//
// Configuration
//   LC3_ARB_TIMEOUT_EN  when defined, a transfer without mem_ready for TIMEOUT XFER cycles is
//                       aborted (owner ready pulsed, reads return 16'hDEAD, err set).
//                       When undefined, err is tied 0 and XFER waits indefinitely.

module lc3_mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15  // must be >= 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dev_req,
  input  logic          dev_we,
  input  logic [AW-1:0] dev_addr,
  input  logic [DW-1:0] dev_wdata,
  output logic [DW-1:0] dev_rdata,
  output logic          dev_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    grant,
  output logic          err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic OwnCpu = 1'b0;
  localparam logic OwnDev = 1'b1;

  localparam logic [DW-1:0] AbortData = DW'(16'hDEAD);

  // Registered state
  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_last_owner;
  logic          r_we;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dev_rdata;
  logic          r_cpu_ready;
  logic          r_dev_ready;
  logic [1:0]    r_grant;

  // Next-state values
  logic [1:0]    w_state;
  logic          w_owner;
  logic          w_last_owner;
  logic          w_we;
  logic          w_mem_en;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic [DW-1:0] w_cpu_rdata;
  logic [DW-1:0] w_dev_rdata;
  logic          w_cpu_ready;
  logic          w_dev_ready;
  logic [1:0]    w_grant;

  // Arbitration helpers
  logic          w_any_req;
  logic          w_winner;
  logic          w_finish;
  logic          w_expire;
  logic [DW-1:0] w_read_data;

`ifdef LC3_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt;
  logic            r_err;
  logic            w_err;

  // Expiry fires on the edge closing the TIMEOUT-th XFER cycle; mem_ready on that same
  // cycle takes precedence.
  assign w_expire = ~mem_ready && (r_cnt == CntW'(TIMEOUT - 1));
  assign err      = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_expire         = 1'b0;
  assign err              = 1'b0;
`endif

  // CPU wins when alone, or on a tie when the device owned the previous transfer.
  assign w_any_req   = cpu_req | dev_req;
  assign w_winner    = (cpu_req && (!dev_req || (r_last_owner == OwnDev))) ? OwnCpu : OwnDev;
  assign w_finish    = mem_ready | w_expire;
  assign w_read_data = mem_ready ? mem_rdata : AbortData;

  always_comb begin
    w_state      = r_state;
    w_owner      = r_owner;
    w_last_owner = r_last_owner;
    w_we         = r_we;
    w_mem_en     = r_mem_en;
    w_mem_we     = r_mem_we;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_cpu_rdata  = r_cpu_rdata;
    w_dev_rdata  = r_dev_rdata;
    w_cpu_ready  = r_cpu_ready;
    w_dev_ready  = r_dev_ready;
    w_grant      = r_grant;
`ifdef LC3_ARB_TIMEOUT_EN
    w_cnt        = r_cnt;
    w_err        = r_err;
`endif

    case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state      = StXfer;
          w_owner      = w_winner;
          w_last_owner = w_winner;
          w_mem_en     = 1'b1;
          if (w_winner == OwnCpu) begin
            w_we        = cpu_we;
            w_mem_we    = cpu_we;
            w_mem_addr  = cpu_addr;
            w_mem_wdata = cpu_wdata;
            w_grant     = 2'b01;
          end else begin
            w_we        = dev_we;
            w_mem_we    = dev_we;
            w_mem_addr  = dev_addr;
            w_mem_wdata = dev_wdata;
            w_grant     = 2'b10;
          end
`ifdef LC3_ARB_TIMEOUT_EN
          w_cnt = '0;
`endif
        end
      end

      StXfer: begin
        // Requester inputs are deliberately not looked at here; the latched copy drives mem.
        if (w_finish) begin
          w_state  = StDone;
          w_mem_en = 1'b0;
          w_mem_we = 1'b0;
          if (r_owner == OwnCpu) begin
            w_cpu_ready = 1'b1;
            if (!r_we) w_cpu_rdata = w_read_data;
          end else begin
            w_dev_ready = 1'b1;
            if (!r_we) w_dev_rdata = w_read_data;
          end
`ifdef LC3_ARB_TIMEOUT_EN
          if (w_expire) w_err = 1'b1;
`endif
        end else begin
`ifdef LC3_ARB_TIMEOUT_EN
          w_cnt = r_cnt + 1'b1;
`endif
        end
      end

      StDone: begin
        w_state     = StIdle;
        w_cpu_ready = 1'b0;
        w_dev_ready = 1'b0;
        w_grant     = 2'b00;
      end

      default: begin
        w_state     = StIdle;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_cpu_ready = 1'b0;
        w_dev_ready = 1'b0;
        w_grant     = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_owner      <= OwnCpu;
      r_last_owner <= OwnDev;
      r_we         <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_dev_rdata  <= '0;
      r_cpu_ready  <= 1'b0;
      r_dev_ready  <= 1'b0;
      r_grant      <= 2'b00;
    end else begin
      r_state      <= w_state;
      r_owner      <= w_owner;
      r_last_owner <= w_last_owner;
      r_we         <= w_we;
      r_mem_en     <= w_mem_en;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_cpu_rdata  <= w_cpu_rdata;
      r_dev_rdata  <= w_dev_rdata;
      r_cpu_ready  <= w_cpu_ready;
      r_dev_ready  <= w_dev_ready;
      r_grant      <= w_grant;
    end
  end

`ifdef LC3_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt;
      r_err <= w_err;
    end
  end
`endif

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign dev_rdata = r_dev_rdata;
  assign dev_ready = r_dev_ready;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign grant     = r_grant;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: reset state, single CPU read, latched address,
// device write with wait states, round-robin back-to-back ties, asynchronous reset abort,
// and (with LC3_ARB_TIMEOUT_EN) the timeout abort path.

module tb_lc3_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cpu_req, cpu_we, dev_req, dev_we;
  logic [15:0] cpu_addr, cpu_wdata, dev_addr, dev_wdata;
  logic [15:0] cpu_rdata, dev_rdata;
  logic        cpu_ready, dev_ready;
  logic        mem_en, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;
  logic        err;

  int n_vec;
  int n_err;

  lc3_mem_arbiter #(
    .AW     (16),
    .DW     (16),
    .TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .dev_req  (dev_req),
    .dev_we   (dev_we),
    .dev_addr (dev_addr),
    .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata),
    .dev_ready(dev_ready),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .grant    (grant),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0;
    cpu_wdata = 16'h0;
    dev_req   = 1'b0;
    dev_we    = 1'b0;
    dev_addr  = 16'h0;
    dev_wdata = 16'h0;
    mem_ready = 1'b0;
    mem_rdata = 16'h0;
    #1 reset_n = 1'b0;
    tick();

    // Reset state
    chk("rst_mem_en", mem_en, 0);
    chk("rst_grant", grant, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_dev_ready", dev_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 1: CPU read of 16'h3000, mem_ready in first XFER cycle
    cpu_req  = 1'b1;
    cpu_addr = 16'h3000;
    tick();
    chk("t1_xfer_grant", grant, 2'b01);
    chk("t1_xfer_en", mem_en, 1);
    chk("t1_xfer_we", mem_we, 0);
    chk("t1_xfer_addr", mem_addr, 16'h3000);
    chk("t1_xfer_cready", cpu_ready, 0);
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    chk("t1_done_cready", cpu_ready, 1);
    chk("t1_done_rdata", cpu_rdata, 16'h1234);
    chk("t1_done_grant", grant, 2'b01);
    chk("t1_done_en", mem_en, 0);
    chk("t1_done_dready", dev_ready, 0);
    cpu_req   = 1'b0;
    mem_ready = 1'b0;
    tick();
    chk("t1_idle_cready", cpu_ready, 0);
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_rdata", cpu_rdata, 16'h1234);

    // 4: CPU address changes during XFER, mem_addr stays latched
    cpu_req  = 1'b1;
    cpu_addr = 16'h3000;
    tick();
    cpu_addr = 16'hFFFF;
    tick();
    chk("t4_addr_held", mem_addr, 16'h3000);
    chk("t4_grant", grant, 2'b01);
    mem_ready = 1'b1;
    mem_rdata = 16'h4321;
    tick();
    chk("t4_done_rdata", cpu_rdata, 16'h4321);
    cpu_req   = 1'b0;
    mem_ready = 1'b0;
    tick();

    // 3: device write FE06 <- 0041 with mem_ready in the third XFER cycle
    dev_req   = 1'b1;
    dev_we    = 1'b1;
    dev_addr  = 16'hFE06;
    dev_wdata = 16'h0041;
    mem_rdata = 16'h5555;
    tick();
    dev_addr  = 16'h0000;
    dev_wdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_we_c%0d", i), mem_we, 1);
      chk($sformatf("t3_addr_c%0d", i), mem_addr, 16'hFE06);
      chk($sformatf("t3_wdata_c%0d", i), mem_wdata, 16'h0041);
      chk($sformatf("t3_grant_c%0d", i), grant, 2'b10);
      chk($sformatf("t3_dready_c%0d", i), dev_ready, 0);
      if (i == 2) mem_ready = 1'b1;
      tick();
    end
    chk("t3_done_dready", dev_ready, 1);
    chk("t3_done_drdata", dev_rdata, 16'h0000);
    chk("t3_done_cready", cpu_ready, 0);
    dev_req   = 1'b0;
    dev_we    = 1'b0;
    mem_ready = 1'b0;
    tick();
    chk("t3_idle_dready", dev_ready, 0);

    // 2: both requesting, mem_ready held high; last owner was DEV so CPU goes first
    cpu_req   = 1'b1;
    dev_req   = 1'b1;
    cpu_addr  = 16'h0100;
    dev_addr  = 16'h0200;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rdata = 16'hA000 + 16'(k);
      chk($sformatf("t2_idle_grant_%0d", k), grant, 0);
      tick();
      chk($sformatf("t2_xfer_grant_%0d", k), grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t2_xfer_addr_%0d", k), mem_addr, (k % 2 == 0) ? 16'h0100 : 16'h0200);
      tick();
      chk($sformatf("t2_cready_%0d", k), cpu_ready, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("t2_dready_%0d", k), dev_ready, (k % 2 == 0) ? 0 : 1);
      if (k % 2 == 0) chk($sformatf("t2_crdata_%0d", k), cpu_rdata, 16'hA000 + k);
      else chk($sformatf("t2_drdata_%0d", k), dev_rdata, 16'hA000 + k);
      tick();
    end
    chk("t2_end_crdata", cpu_rdata, 16'hA002);
    chk("t2_end_drdata", dev_rdata, 16'hA003);
    cpu_req   = 1'b0;
    dev_req   = 1'b0;
    mem_ready = 1'b0;
    tick();

    // 5: reset in second XFER cycle; last owner DEV before, then reset -> CPU wins tie anyway
    cpu_req  = 1'b1;
    cpu_addr = 16'h3000;
    tick();
    tick();
    chk("t5_pre_en", mem_en, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_async_en", mem_en, 0);
    chk("t5_async_grant", grant, 0);
    cpu_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ready = 1'b0;
    tick();
    chk("t5_no_cready", cpu_ready, 0);
    chk("t5_cpu_rdata", cpu_rdata, 0);
    cpu_req = 1'b1;
    dev_req = 1'b1;
    tick();
    chk("t5_tie_grant", grant, 2'b01);
    cpu_req   = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk("t5_done_cready", cpu_ready, 1);
    chk("t5_done_dready", dev_ready, 0);
    mem_ready = 1'b0;
    tick();
    tick();
    chk("t5_dev_waits", grant, 2'b10);
    mem_ready = 1'b1;
    tick();
    chk("t5_dev_done", dev_ready, 1);
    dev_req   = 1'b0;
    mem_ready = 1'b0;
    tick();

`ifdef LC3_ARB_TIMEOUT_EN
    // 6: CPU read with no mem_ready aborts after 15 XFER cycles
    cpu_req  = 1'b1;
    cpu_addr = 16'h3000;
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("t6_still_xfer", grant, 2'b01);
    chk("t6_no_cready", cpu_ready, 0);
    chk("t6_no_err", err, 0);
    tick();
    chk("t6_cready", cpu_ready, 1);
    chk("t6_rdata", cpu_rdata, 16'hDEAD);
    chk("t6_err", err, 1);
    cpu_req = 1'b0;
    tick();
    chk("t6_err_sticky", err, 1);
    dev_req   = 1'b1;
    dev_we    = 1'b0;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ready = 1'b1;
    tick();
    chk("t6_dev_ready", dev_ready, 1);
    chk("t6_dev_rdata", dev_rdata, 16'hBEEF);
    chk("t6_err_still", err, 1);
    dev_req   = 1'b0;
    mem_ready = 1'b0;
    tick();
`else
    chk("end_err_zero", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
